square_drawer: RTL and testbench
================================

Name: square_drawer

Overview:
- Downstream consumer of the square location picker in the VGA game path.
- On a `start` request it latches the new top-left (`x_loc`, `y_loc`).
- It first erases the previously drawn square, if one exists, by writing colour 0 over it.
- It then draws a filled SIDE x SIDE square at the new location, one pixel per clock, into the frame-buffer write port. It reports completion with a level `done` handshake.

Parameters:
- SIDE, 20, square edge length in pixels (2..64).
- SCREEN_W, 640, visible width; columns >= SCREEN_W are clipped.
- SCREEN_H, 480, visible height; rows >= SCREEN_H are clipped.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
- start  input  1  level request; held high until `done` is seen, then dropped.
- x_loc  input  11  top-left column of the new square; sampled only on the IDLE->pass edge.
- y_loc  input  11  top-left row of the new square; sampled with x_loc.
- x  output  11  pixel column to write.
- y  output  11  pixel row to write.
- pixel_color  output  1  1 = draw (white), 0 = erase (black).
- pixel_write  output  1  frame-buffer write enable for (x, y, pixel_color).
- done  output  1  high while in state FINISHED.

Behaviour:
- Reset (reset=0, async):
  - state = IDLE; cx = cy = 0.
  - cur_x = cur_y = old_x = old_y = 0; have_old = 0.
  - Outputs: x = 0, y = 0, pixel_color = 0, pixel_write = 0, done = 0.
  - Reset mid-pass abandons the pass. No further writes occur, and have_old = 0, so the next request draws without erasing.
- States: IDLE, ERASE, DRAW, FINISHED.
- IDLE:
  - start=1 at a posedge: latch cur_x <= x_loc and cur_y <= y_loc; clear cx and cy.
  - Go to ERASE if have_old=1, else go to DRAW.
  - start=0: stay in IDLE.
- ERASE: one pixel per cycle.
  - x = old_x + cx, y = old_y + cy, pixel_color = 0.
- DRAW: one pixel per cycle.
  - x = cur_x + cx, y = cur_y + cy, pixel_color = 1.
- Scan order (ERASE and DRAW): raster within the square.
  - cx increments each cycle.
  - At cx = SIDE-1, cx wraps to 0 and cy increments.
- End of a pass, at cx = cy = SIDE-1:
  - ERASE -> DRAW, with cx and cy cleared.
  - DRAW -> FINISHED; on that same edge old_x <= cur_x, old_y <= cur_y, have_old <= 1.
- FINISHED:
  - done = 1, pixel_write = 0.
  - start=0 -> IDLE. start still 1 -> stay in FINISHED, so there is no retrigger without a low phase on start.
- Outputs x, y, pixel_color and pixel_write are combinational from registered state and counters; x and y hold their last value outside ERASE/DRAW.
- pixel_write = (state is ERASE or DRAW) && x < SCREEN_W && y < SCREEN_H.
  - Clipped pixels still consume their cycle, so pass length is fixed.
- Arithmetic: x and y are 11-bit unsigned sums with no overflow for legal inputs (max 2047 + 63 is not reached, since inputs are < 1024 in practice).
- Latency:
  - Start sampled at edge k means the first pixel is presented during cycle k+1.
  - First request after reset: DRAW only, so done rises SIDE^2 cycles after the start edge.
  - Later requests: ERASE + DRAW, so done rises 2*SIDE^2 cycles after the start edge.
- Changes to x_loc/y_loc after the latch edge have no effect on the pass in progress.

Test Plan:
- Basic draw: SIDE=4, reset released, x_loc=10, y_loc=20, start=1.
  - Expect 16 writes with pixel_color=1, in order (10,20), (11,20) … (13,23).
  - done rises 16 cycles after the start edge; drop start, then IDLE next edge.
- Erase then draw: after the basic draw, request (50,50).
  - Expect 16 writes with colour 0 at (10..13, 20..23), then 16 writes with colour 1 at (50..53, 50..53).
  - done rises 32 cycles after the start edge.
- Clipping: SIDE=20, location (620,470).
  - Expect 400 scan cycles; pixel_write=1 only for x 620..639 and y 470..479 (200 writes).
  - No write with x >= 640 or y >= 480.
- Held start: keep start=1 for 10 cycles after done.
  - done stays 1, pixel_write stays 0, no new pass starts.
  - After start drops and rises again, a new pass begins.
- Async reset mid-DRAW: assert reset=0 between clock edges after 5 pixels.
  - Outputs go to 0 and done to 0 immediately.
  - After release, a request at (0,0) performs DRAW only: 16 writes, no erase pass.
- Input change during pass: change x_loc/y_loc every cycle after the latch edge.
  - Drawn coordinates match only the latched values.

Source files
------------

// File: rtl/square_drawer.sv
// Erases the previously drawn square (colour 0), then draws a filled SIDE x SIDE
// square (colour 1) at a newly latched location, one frame-buffer pixel per clock.
module square_drawer #(
    parameter int SIDE     = 20,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] x_loc,
    input  logic [10:0] y_loc,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        pixel_color,
    output logic        pixel_write,
    output logic        done,
    output logic [1:0]  debug_state
);

    localparam int CW = (SIDE > 1) ? $clog2(SIDE) : 1;
    localparam logic [CW-1:0] LAST  = CW'(SIDE - 1);
    localparam logic [10:0]   X_LIM = 11'(SCREEN_W);
    localparam logic [10:0]   Y_LIM = 11'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ERASE    = 2'd1,
        DRAW     = 2'd2,
        FINISHED = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cx, cy, cx_nxt, cy_nxt;
    logic [10:0]   cur_x, cur_y, cur_x_nxt, cur_y_nxt;
    logic [10:0]   old_x, old_y, old_x_nxt, old_y_nxt;
    logic [10:0]   last_x, last_y;
    logic          have_old, have_old_nxt;

    logic          active;
    logic          row_end, pass_end;
    logic [10:0]   base_x, base_y, scan_x, scan_y;

    // Handshake: start is a level request held until done is seen; done stays
    // high in FINISHED until start drops, so one request yields exactly one pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cx       <= '0;
            cy       <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            old_x    <= '0;
            old_y    <= '0;
            have_old <= 1'b0;
            last_x   <= '0;
            last_y   <= '0;
        end else begin
            state    <= state_nxt;
            cx       <= cx_nxt;
            cy       <= cy_nxt;
            cur_x    <= cur_x_nxt;
            cur_y    <= cur_y_nxt;
            old_x    <= old_x_nxt;
            old_y    <= old_y_nxt;
            have_old <= have_old_nxt;
            if (active) begin
                last_x <= scan_x;
                last_y <= scan_y;
            end
        end
    end

    assign row_end  = (cx == LAST);
    assign pass_end = row_end && (cy == LAST);

    always_comb begin
        state_nxt    = state;
        cx_nxt       = cx;
        cy_nxt       = cy;
        cur_x_nxt    = cur_x;
        cur_y_nxt    = cur_y;
        old_x_nxt    = old_x;
        old_y_nxt    = old_y;
        have_old_nxt = have_old;
        case (state)
            IDLE: begin
                if (start) begin
                    cur_x_nxt = x_loc;
                    cur_y_nxt = y_loc;
                    cx_nxt    = '0;
                    cy_nxt    = '0;
                    state_nxt = have_old ? ERASE : DRAW;
                end
            end
            ERASE, DRAW: begin
                if (row_end) begin
                    cx_nxt = '0;
                    cy_nxt = cy + CW'(1);
                end else begin
                    cx_nxt = cx + CW'(1);
                end
                if (pass_end) begin
                    cx_nxt = '0;
                    cy_nxt = '0;
                    if (state == ERASE) begin
                        state_nxt = DRAW;
                    end else begin
                        // The square just finished becomes the one to erase next time.
                        state_nxt    = FINISHED;
                        old_x_nxt    = cur_x;
                        old_y_nxt    = cur_y;
                        have_old_nxt = 1'b1;
                    end
                end
            end
            FINISHED: begin
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign active = (state == ERASE) || (state == DRAW);
    assign base_x = (state == ERASE) ? old_x : cur_x;
    assign base_y = (state == ERASE) ? old_y : cur_y;
    assign scan_x = base_x + {{(11 - CW){1'b0}}, cx};
    assign scan_y = base_y + {{(11 - CW){1'b0}}, cy};

    // Off-screen pixels still take their cycle; only the write strobe is masked.
    assign x           = active ? scan_x : last_x;
    assign y           = active ? scan_y : last_y;
    assign pixel_color = (state == DRAW);
    assign pixel_write = active && (scan_x < X_LIM) && (scan_y < Y_LIM);
    assign done        = (state == FINISHED);
    assign debug_state = state;

endmodule

// File: tb/tb_square_drawer.sv
// Randomized bench for square_drawer: an event-queue model of the expected pixel
// stream is compared against the DUT every cycle, plus literal latency/count checks.
module tb_square_drawer;

    localparam int SIDE = 4;
    localparam int SW   = 640;
    localparam int SH   = 480;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] x_loc, y_loc;
    logic [10:0] x, y;
    logic        pixel_color, pixel_write, done;
    logic [1:0]  debug_state;

    int checks = 0;
    int passes = 0;

    square_drawer #(.SIDE(SIDE), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .reset(reset), .start(start), .x_loc(x_loc), .y_loc(y_loc),
        .x(x), .y(y), .pixel_color(pixel_color), .pixel_write(pixel_write),
        .done(done), .debug_state(debug_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: each request becomes a queue of {x, y, colour} pixels to present.
    logic [22:0] exp_q[$];
    int          m_phase;  // 0 idle, 1 scanning, 2 finished
    bit          m_have_old;
    logic [10:0] m_old_x, m_old_y, m_new_x, m_new_y, m_last_x, m_last_y;

    task automatic push_square(input logic [10:0] bx, input logic [10:0] by, input logic c);
        for (int j = 0; j < SIDE; j++)
            for (int i = 0; i < SIDE; i++)
                exp_q.push_back({11'(bx + i), 11'(by + j), c});
    endtask

    initial begin
        m_phase = 0; m_have_old = 0;
        m_old_x = 0; m_old_y = 0; m_new_x = 0; m_new_y = 0; m_last_x = 0; m_last_y = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_phase = 0; m_have_old = 0;
                m_old_x = 0; m_old_y = 0; m_last_x = 0; m_last_y = 0;
                exp_q.delete();
            end else begin
                case (m_phase)
                    0: if (start) begin
                        m_new_x = x_loc;
                        m_new_y = y_loc;
                        if (m_have_old) push_square(m_old_x, m_old_y, 1'b0);
                        push_square(m_new_x, m_new_y, 1'b1);
                        m_phase = 1;
                    end
                    1: begin
                        logic [22:0] e;
                        e = exp_q.pop_front();
                        m_last_x = e[22:12];
                        m_last_y = e[11:1];
                        if (exp_q.size() == 0) begin
                            m_phase = 2;
                            m_have_old = 1;
                            m_old_x = m_new_x;
                            m_old_y = m_new_y;
                        end
                    end
                    default: if (!start) m_phase = 0;
                endcase
            end
        end
    end

    // scoreboard compare, every cycle while out of reset
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (m_phase == 1) begin
                logic [22:0] e;
                e = exp_q[0];
                check("x", int'(x), int'(e[22:12]));
                check("y", int'(y), int'(e[11:1]));
                check("color", int'(pixel_color), int'(e[0]));
                check("write", int'(pixel_write),
                      int'((int'(e[22:12]) < SW) && (int'(e[11:1]) < SH)));
                check("done_busy", int'(done), 0);
            end else begin
                check("x_hold", int'(x), int'(m_last_x));
                check("y_hold", int'(y), int'(m_last_y));
                check("write_idle", int'(pixel_write), 0);
                check("done", int'(done), int'(m_phase == 2));
            end
        end
    end

    function automatic int visible(input int b, input int lim);
        int n = 0;
        for (int i = 0; i < SIDE; i++) if (b + i < lim) n++;
        return n;
    endfunction

    // driver: one full request/done/release handshake
    task automatic request(input logic [10:0] rx, input logic [10:0] ry, input bit scramble,
                           input int hold, output int lat, output int wr,
                           output int fx, output int fy, output int fc);
        @(negedge clk); #1;
        x_loc = rx; y_loc = ry; start = 1'b1;
        @(posedge clk);
        lat = 0; wr = 0; fx = -1; fy = -1; fc = -1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (lat == 0) begin fx = int'(x); fy = int'(y); fc = int'(pixel_color); end
            if (pixel_write) wr++;
            #1;
            if (scramble) begin
                x_loc = 11'($urandom_range(0, 1023));
                y_loc = 11'($urandom_range(0, 1023));
            end
            lat++;
            if (lat > 2 * SIDE * SIDE + 8) begin
                check("done_timeout", lat, 2 * SIDE * SIDE);
                break;
            end
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check("held_done", int'(done), 1);
            check("held_write", int'(pixel_write), 0);
        end
        #1 start = 1'b0;
        @(negedge clk);
        check("idle_after_drop", int'(done), 0);
    endtask

    initial begin
        int lat, wr, fx, fy, fc, ox, oy, nx, ny;
        reset = 1'b0; start = 1'b0; x_loc = '0; y_loc = '0;
        #3;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_write", int'(pixel_write), 0);
        check("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // basic draw: no previous square
        request(11'd10, 11'd20, 1'b0, 0, lat, wr, fx, fy, fc);
        check("basic_lat", lat, 16);
        check("basic_writes", wr, 16);
        check("basic_first_x", fx, 10);
        check("basic_first_y", fy, 20);
        check("basic_first_c", fc, 1);

        // erase then draw
        request(11'd50, 11'd50, 1'b0, 0, lat, wr, fx, fy, fc);
        check("ed_lat", lat, 32);
        check("ed_writes", wr, 32);
        check("ed_first_x", fx, 10);
        check("ed_first_y", fy, 20);
        check("ed_first_c", fc, 0);

        // clipping at bottom-right corner: 2x2 of the 4x4 square visible
        request(11'd638, 11'd478, 1'b0, 0, lat, wr, fx, fy, fc);
        check("clip_lat", lat, 32);
        check("clip_writes", wr, 20);

        // held start, then a fresh pass
        request(11'd100, 11'd100, 1'b0, 10, lat, wr, fx, fy, fc);
        check("hold_lat", lat, 32);
        check("hold_writes", wr, 16 + 4);
        check("hold_first_x", fx, 638);

        // location inputs change every cycle during the pass
        request(11'd200, 11'd300, 1'b1, 0, lat, wr, fx, fy, fc);
        check("scramble_lat", lat, 32);
        check("scramble_writes", wr, 32);

        // async reset five pixels into DRAW
        @(negedge clk); #1;
        x_loc = 11'd5; y_loc = 11'd5; start = 1'b1;
        @(posedge clk);
        repeat (16 + 5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_y", int'(y), 0);
        check("mid_rst_write", int'(pixel_write), 0);
        check("mid_rst_done", int'(done), 0);
        start = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        request(11'd0, 11'd0, 1'b0, 0, lat, wr, fx, fy, fc);
        check("post_rst_lat", lat, 16);
        check("post_rst_writes", wr, 16);
        check("post_rst_first_c", fc, 1);

        // randomized requests
        ox = 0; oy = 0;
        for (int n = 0; n < 24; n++) begin
            nx = $urandom_range(0, 1023);
            ny = (n % 3 == 0) ? $urandom_range(470, 490) : $urandom_range(0, 1023);
            request(11'(nx), 11'(ny), bit'($urandom_range(0, 1)), $urandom_range(0, 3),
                    lat, wr, fx, fy, fc);
            check("rand_lat", lat, 32);
            check("rand_writes", wr,
                  visible(ox, SW) * visible(oy, SH) + visible(nx, SW) * visible(ny, SH));
            ox = nx; oy = ny;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
